mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data requester, memory and status signals of the shared memory port arbiter.
// master = requester and memory side, slave = arbiter side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_if;
   logic              stall_mem;
   logic              busy;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_ready, if_rdata, d_ready, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  stall_if, stall_mem, busy
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_ready, if_rdata, d_ready, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output stall_if, stall_mem, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and data requesters, one access at a time.
// Ready comes MEM_LAT+2 cycles after the IDLE cycle that granted; requests are held (stalled) until ready.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam logic [3:0] LAT  = 4'(MEM_LAT);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        starve_cnt;
   logic [3:0]        wait_cnt;
   logic              owner_d;
   logic              lat_we;
   logic              grant_d;
   logic              grant_f;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              if_ready;
   logic              d_ready;
   logic [DATA_W-1:0] if_rdata;
   logic [DATA_W-1:0] d_rdata;

   // Data has priority unless fetch has already lost STARVE_MAX grants in a row.
   assign grant_d = bus.d_req && !(bus.if_req && (starve_cnt == SMAX));
   assign grant_f = bus.if_req && !grant_d;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.if_req || bus.d_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (wait_cnt == 4'd1) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         wait_cnt   <= '0;
         owner_d    <= 1'b0;
         lat_we     <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_ready   <= 1'b0;
         d_ready    <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         state    <= state_nxt;
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         if_ready <= 1'b0;
         d_ready  <= 1'b0;
         case (state)
            IDLE: begin
               // mem_addr/mem_wdata double as the latched request and hold afterwards.
               if (grant_d) begin
                  owner_d    <= 1'b1;
                  lat_we     <= bus.d_we;
                  mem_addr   <= bus.d_addr;
                  mem_wdata  <= bus.d_wdata;
                  mem_en     <= 1'b1;
                  mem_we     <= bus.d_we;
                  starve_cnt <= !bus.if_req       ? 4'd0 :
                                (starve_cnt == SMAX) ? SMAX : starve_cnt + 4'd1;
               end else if (grant_f) begin
                  owner_d    <= 1'b0;
                  lat_we     <= 1'b0;
                  mem_addr   <= bus.if_addr;
                  mem_en     <= 1'b1;
                  mem_we     <= 1'b0;
                  starve_cnt <= 4'd0;
               end
            end
            ISSUE: wait_cnt <= LAT;
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  if (owner_d) begin
                     if (!lat_we) d_rdata <= bus.mem_rdata;
                     d_ready <= 1'b1;
                  end else begin
                     if_rdata <= bus.mem_rdata;
                     if_ready <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_en    = mem_en;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.if_ready  = if_ready;
   assign bus.d_ready   = d_ready;
   assign bus.if_rdata  = if_rdata;
   assign bus.d_rdata   = d_rdata;
   assign bus.stall_if  = bus.if_req & ~if_ready;
   assign bus.stall_mem = bus.d_req & ~d_ready;
   assign bus.busy      = (state != IDLE);
endmodule
